// File: rtl/acc_tracker_pkg.sv
// Shared FSM state, counter-width helpers and the 0.5 threshold constant
// for the training-loop accuracy tracker.
package acc_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // clog2 that never collapses to a zero-width vector
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic longint half_thresh(input int frac_bits);
        return longint'(1) << (frac_bits - 1);
    endfunction

endpackage

// File: rtl/acc_window.sv
// Circular bit buffer over the last WINDOW case results with a running
// count of set bits; unwritten slots read 0.
module acc_window
    import acc_tracker_pkg::*;
#(
    parameter int WINDOW = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       sample,
    output logic [cw(WINDOW+1)-1:0]    count
);

    localparam int PW = cw(WINDOW);
    localparam int CW = cw(WINDOW + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(WINDOW - 1);

    logic [WINDOW-1:0] hist;
    logic [PW-1:0]     ptr;
    logic              old_bit;

    assign old_bit = hist[ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            hist[ptr] <= sample;
            ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            // old_bit is only ever 1 when count already includes it
            count     <= count - CW'(old_bit) + CW'(sample);
        end
    end

endmodule

// File: rtl/acc_tracker.sv
// Block-cycle sequencer and accuracy bookkeeping for DNN training runs.
// Define ACC_TRACKER_THRESH_EN to score raw activations against 0.5.
module acc_tracker
    import acc_tracker_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int CPC         = 18,
    parameter int PIPE_DELAY  = 2,
    parameter int WINDOW      = 1000,
    parameter int TRAIN_CASES = 10000,
    parameter int EPOCHS      = 10,
    parameter int WIDTH       = 32,
    parameter int FRAC_BITS   = 21
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic [LANES-1:0]                       a_out,
    input  logic [LANES-1:0]                       y_out,
`ifdef ACC_TRACKER_THRESH_EN
    input  logic [LANES*WIDTH-1:0]                 a_act,
`endif
    output logic [cw(CPC)-1:0]                     cycle_index,
    output logic                                   cycle_start,
    output logic [cw(CPC-PIPE_DELAY)-1:0]          sel_network,
    output logic [cw(TRAIN_CASES)-1:0]             sel_tc,
    output logic [cw(EPOCHS+1)-1:0]                epoch,
    output logic [cw(TRAIN_CASES*EPOCHS+1)-1:0]    num_train,
    output logic                                   case_valid,
    output logic                                   case_correct,
    output logic [cw(TRAIN_CASES*EPOCHS+1)-1:0]    total_error,
    output logic [cw(WINDOW+1)-1:0]                recent_correct,
    output logic                                   done
);

    localparam int CIW = cw(CPC);
    localparam int SNW = cw(CPC - PIPE_DELAY);
    localparam int TCW = cw(TRAIN_CASES);
    localparam int NW  = cw(TRAIN_CASES * EPOCHS + 1);

    localparam logic [CIW-1:0] IDX_LAST = CIW'(CPC - 1);
    localparam logic [CIW-1:0] IDX_CMP  = CIW'(PIPE_DELAY);
    localparam logic [CIW-1:0] IDX_NET  = CIW'(CPC - PIPE_DELAY);
    localparam logic [TCW-1:0] TC_LAST  = TCW'(TRAIN_CASES - 1);
    localparam logic [NW-1:0]  NUM_LAST = NW'(TRAIN_CASES * EPOCHS - 1);

    state_t          state;
    state_t          state_d;
    logic [LANES-1:0] pred;
    logic            advance;
    logic            last;
    logic            score;
    logic            hit;
    logic            err_flag;
    logic            case_bad;

`ifdef ACC_TRACKER_THRESH_EN
    localparam logic signed [WIDTH-1:0] THRESH = WIDTH'(half_thresh(FRAC_BITS));

    always_comb begin
        pred = '0;
        for (int i = 0; i < LANES; i++) begin
            pred[i] = $signed(a_act[i*WIDTH +: WIDTH]) > THRESH;
        end
    end
`else
    assign pred = a_out;
`endif

    assign advance  = (state == RUN) && en;
    assign last     = (cycle_index == IDX_LAST);
    assign score    = advance && last;
    assign hit      = (cycle_index >= IDX_CMP) && (|(pred ^ y_out));
    assign case_bad = err_flag | hit;

    assign done        = (state == DONE);
    assign cycle_start = advance && (cycle_index == '0);
    assign sel_network = (cycle_index < IDX_NET) ? SNW'(cycle_index) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (score && num_train == NUM_LAST) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_index  <= '0;
            err_flag     <= 1'b0;
            case_valid   <= 1'b0;
            case_correct <= 1'b0;
            num_train    <= '0;
            total_error  <= '0;
            sel_tc       <= '0;
            epoch        <= '0;
        end else begin
            case_valid <= score;
            if (advance) begin
                cycle_index <= last ? '0 : cycle_index + 1'b1;
                err_flag    <= last ? 1'b0 : case_bad;
            end
            if (score) begin
                case_correct <= ~case_bad;
                num_train    <= num_train + 1'b1;
                total_error  <= total_error + NW'(case_bad);
                if (sel_tc == TC_LAST) begin
                    sel_tc <= '0;
                    epoch  <= epoch + 1'b1;
                end else begin
                    sel_tc <= sel_tc + 1'b1;
                end
            end
        end
    end

    acc_window #(
        .WINDOW (WINDOW)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .push   (score),
        .sample (~case_bad),
        .count  (recent_correct)
    );

endmodule

// File: tb/tb_acc_tracker.sv
// Scoreboard bench for acc_tracker with a small configuration
// (CPC=6, PIPE_DELAY=2, WINDOW=4, TRAIN_CASES=3, EPOCHS=2).
module tb_acc_tracker;

    localparam int LANES = 1;
    localparam int CPC = 6;
    localparam int PD = 2;
    localparam int WIN = 4;
    localparam int TC = 3;
    localparam int EP = 2;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    logic en;
    logic [LANES-1:0] a_out;
    logic [LANES-1:0] y_out;
    logic [LANES*WIDTH-1:0] a_act;
    logic [2:0] cycle_index;
    logic cycle_start;
    logic [1:0] sel_network;
    logic [1:0] sel_tc;
    logic [1:0] epoch;
    logic [2:0] num_train;
    logic case_valid;
    logic case_correct;
    logic [2:0] total_error;
    logic [2:0] recent_correct;
    logic done;

    acc_tracker #(
        .LANES(LANES), .CPC(CPC), .PIPE_DELAY(PD), .WINDOW(WIN),
        .TRAIN_CASES(TC), .EPOCHS(EP), .WIDTH(WIDTH), .FRAC_BITS(21)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .a_out(a_out), .y_out(y_out),
`ifdef ACC_TRACKER_THRESH_EN
        .a_act(a_act),
`endif
        .cycle_index(cycle_index), .cycle_start(cycle_start),
        .sel_network(sel_network), .sel_tc(sel_tc), .epoch(epoch),
        .num_train(num_train), .case_valid(case_valid),
        .case_correct(case_correct), .total_error(total_error),
        .recent_correct(recent_correct), .done(done)
    );

    typedef struct {
        int ok;
        int err;
        int recent;
        int sel;
        int ep;
        int num;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;
    int m_num, m_err, m_sel, m_ep;
    int hist[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && case_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_case_valid: got 1, expected 0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("case_correct", case_correct, e.ok);
                chk("total_error", total_error, e.err);
                chk("recent_correct", recent_correct, e.recent);
                chk("sel_tc", sel_tc, e.sel);
                chk("epoch", epoch, e.ep);
                chk("num_train", num_train, e.num);
            end
        end
    end

    task automatic push_exp(input int ok);
        exp_t x;
        int s;
        m_num++;
        m_err += (ok == 0) ? 1 : 0;
        hist.push_back(ok);
        if (hist.size() > WIN) void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_sel = (m_sel + 1) % TC;
        if (m_sel == 0) m_ep++;
        x.ok = ok; x.err = m_err; x.recent = s;
        x.sel = m_sel; x.ep = m_ep; x.num = m_num;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1;
        en = 0;
        a_out = '0;
        y_out = '0;
        #2;
        chk("rst_cycle_index", cycle_index, 0);
        chk("rst_num_train", num_train, 0);
        chk("rst_recent", recent_correct, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        m_num = 0; m_err = 0; m_sel = 0; m_ep = 0;
        hist.delete();
        exp_q.delete();
        reset = 0;
        en = 1;
        @(posedge clk);
        #1;
    endtask

    // mis: cycle index of a single injected mismatch, -1 for none
    task automatic run_case(input int mis);
        push_exp((mis >= PD) ? 0 : 1);
        for (int k = 0; k < CPC; k++) begin
            a_out = (k == mis) ? 1'b1 : 1'b0;
            chk("cycle_index", cycle_index, k);
            if (k == 0) chk("cycle_start", cycle_start, 1);
            if (k == 4) chk("sel_network_hi", sel_network, 0);
            @(posedge clk);
            #1;
        end
        a_out = '0;
        chk("case_valid_pulse", case_valid, 1);
    endtask

    initial begin
        a_act = '0;
        // all cases match, run to completion
        do_reset();
        for (int c = 0; c < TC * EP; c++) run_case(-1);
        chk("done_after_run", done, 1);
        for (int i = 0; i < 4; i++) begin
            en = i[0];
            @(posedge clk);
            #1;
            chk("frozen_num", num_train, 6);
            chk("frozen_epoch", epoch, 2);
            chk("frozen_valid", case_valid, 0);
        end
        chk("done_held", done, 1);

        // window behaviour and compare window edges
        do_reset();
        run_case(3);
        run_case(-1);
        run_case(-1);
        run_case(-1);
        run_case(1);
        run_case(5);

        // pause mid-case with a mismatch hidden in the pause
        do_reset();
        push_exp(1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        en = 0;
        a_out = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("pause_index", cycle_index, 3);
            chk("pause_num", num_train, 0);
        end
        en = 1;
        a_out = 1'b0;
        for (int k = 3; k < CPC; k++) begin
            @(posedge clk);
            #1;
        end
        chk("pause_case_valid", case_valid, 1);

        // asynchronous reset mid-case
        a_out = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1;
        #1;
        chk("async_index", cycle_index, 0);
        chk("async_num", num_train, 0);
        chk("async_sel_tc", sel_tc, 0);
        chk("async_err", total_error, 0);
        chk("async_recent", recent_correct, 0);
        chk("async_start", cycle_start, 0);
        do_reset();
        run_case(-1);
        @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc_tracker.md
Name: acc_tracker

Overview:
- Synthesizable successor to the bench-side training-loop bookkeeping. Generates the block-cycle index and the training-case and network-chunk selects for the DNN input muxes.
- Scores each training case by comparing actual against ideal outputs across the valid output cycles.
- Maintains case, epoch, total-error and sliding-window accuracy counters in hardware, so long MNIST runs need no simulator-side logic.
- Sits beside the DNN top, driving the a_in/y_in muxes and observing a_out/y_out.

Parameters:
- LANES, 1, output neurons delivered per clock (z[L-2]/fi[L-2]).
- CPC, 18, clocks per block cycle.
- PIPE_DELAY, 2, clocks from first input to first valid output.
- WINDOW, 1000, number of recent cases used for the accuracy count.
- TRAIN_CASES, 10000, cases per epoch.
- EPOCHS, 10, epochs before done.
- WIDTH, 32, fixed-point activation width (threshold mode only).
- FRAC_BITS, 21, fraction bits (threshold mode only).

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- en, input, 1, run/pause.
- a_out, input, LANES, actual thresholded outputs.
- y_out, input, LANES, ideal outputs.
- cycle_index, output, clog2(CPC), position in block cycle.
- cycle_start, output, 1, high while cycle_index==0 and running.
- sel_network, output, clog2(CPC-PIPE_DELAY), chunk select for input muxes.
- sel_tc, output, clog2(TRAIN_CASES), training-case select.
- epoch, output, clog2(EPOCHS+1), completed epochs.
- num_train, output, clog2(TRAIN_CASES*EPOCHS+1), completed cases.
- case_valid, output, 1, one-clock pulse when a case is scored.
- case_correct, output, 1, result of the scored case, valid with case_valid.
- total_error, output, clog2(TRAIN_CASES*EPOCHS+1), wrong cases so far.
- recent_correct, output, clog2(WINDOW+1), correct cases among the last WINDOW.
- done, output, 1, run complete.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. While reset is high, every output, counter, FSM state and window bit is 0 and the FSM is IDLE.
- FSM IDLE -> RUN: on the first clk edge with en=1.
- FSM RUN -> DONE: on the edge where num_train becomes TRAIN_CASES*EPOCHS.
- FSM DONE: absorbing until reset. done=1; all counters frozen; case_valid=0.
- Pause: in RUN with en=0, every counter holds and compares are ignored. A case straddling a pause completes after resume with its error flag intact.
- cycle_index: counts 0..CPC-1 and wraps. It advances only in RUN with en=1.
- sel_network: equals cycle_index when cycle_index < CPC-PIPE_DELAY, otherwise 0.
- Compare window: at each advancing edge with cycle_index >= PIPE_DELAY, set err_flag if any lane has a_out != y_out. Mismatches at cycle_index < PIPE_DELAY are ignored.
- Case scoring, on the edge where cycle_index==CPC-1 (that cycle's compare included):
  - register case_correct = ~(err_flag | mismatch_now);
  - pulse case_valid for the following clock;
  - clear err_flag;
  - num_train += 1;
  - total_error += ~case_correct.
- sel_tc: increments on the same edge. On TRAIN_CASES-1 it wraps to 0 and epoch += 1 on that edge.
- Window: a WINDOW-deep circular bit buffer with a write pointer wrapping at WINDOW-1.
  - Update rule: recent_correct = recent_correct - old_bit + new_bit, with no underflow.
  - Before WINDOW cases have been scored, old bits read 0, so recent_correct equals the correct-case count so far.
  - Saturates by construction at WINDOW.
- Simultaneous events:
  - The final case's scoring and the DONE transition occur on the same edge; case_valid still pulses once.
  - A reset edge mid-case discards the partial case.

Optional Feature:
- Macro ACC_TRACKER_THRESH_EN.
- When defined: an extra input a_act, width LANES*WIDTH, of signed fixed-point activations.
  - A lane counts as predicted 1 iff a_act > 2^(FRAC_BITS-1) (strictly above 0.5); negative values count as 0.
  - Mismatch means prediction != y_out. The a_out port is ignored.
- When undefined: a_act is absent and a_out is compared directly.

Decomposition:
- Package acc_tracker_pkg holds:
  - FSM state enum {IDLE, RUN, DONE};
  - width helper functions for counter sizes;
  - the 0.5 threshold constant function of FRAC_BITS.
- One sub-module, acc_window: a circular bit buffer with pointer and running count.
  - Inputs: push, bit.
  - Output: count.

Test Plan (LANES=1, CPC=6, PIPE_DELAY=2, WINDOW=4, TRAIN_CASES=3, EPOCHS=2):
- All-match, reset released then en=1 -> case_valid every 6 clocks; recent_correct 1,2,3,4,4,4; total_error=0; done after 6th case.
- Mismatch only at cycle_index 3 of case 0 -> case_correct=0, total_error=1. recent_correct reads 0,1,2,3 over the first four cases, then 4 once case 0 leaves the window.
- Mismatch only at cycle_index 1 -> ignored; case_correct=1.
- Mismatch at cycle_index 5 (last) -> case_correct=0, proving the final-cycle compare is included.
- Sequencing -> sel_tc 0,1,2,0,1,2; epoch 0->1 at case 3 and 2 at case 6; done=1 and all counters frozen thereafter, even with en toggling.
- en=0 for 5 clocks at cycle_index 3, with a mismatch injected during the pause -> counters held and the mismatch ignored; case scored 5 clocks late. Then assert reset mid-case -> all outputs 0 immediately, without waiting for a clock edge.
